// File: rtl/dma_dev_if.sv
// Device-side DMA interface: command FSM, write/read word FIFOs, controller handshake.
// Optional watchdog enabled by defining DMA_DEV_TIMEOUT_EN.

module dma_dev_fifo #(
    parameter int AW = 2,
    parameter int W  = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr_i,
    input  logic          push_i,
    input  logic [W-1:0]  push_dat_i,
    input  logic          pop_i,
    output logic [W-1:0]  head_o,
    output logic [AW:0]   count_o
);
    localparam logic [AW:0] DEPTH = (AW+1)'(1) << AW;

    logic [W-1:0]  mem_q [2**AW];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   cnt_q, cnt_d;
    logic          push_ok, pop_ok;

    assign push_ok = push_i && (cnt_q != DEPTH);
    assign pop_ok  = pop_i && (cnt_q != '0);

    always_comb begin
        cnt_d = cnt_q;
        if (push_ok && !pop_ok)
            cnt_d = cnt_q + (AW+1)'(1);
        else if (pop_ok && !push_ok)
            cnt_d = cnt_q - (AW+1)'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_dat_i;
    end

    // An empty FIFO presents zero so the data outputs are clean out of reset.
    assign head_o  = (cnt_q == '0) ? '0 : mem_q[rd_ptr_q];
    assign count_o = cnt_q;
endmodule

module dma_dev_if #(
    parameter int FIFO_AW = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_rd_wr,
    input  logic [16:0] cmd_addr,
    input  logic [15:0] cmd_words,
    input  logic        src_valid,
    input  logic [15:0] src_data,
    output logic        src_ready,
    output logic        snk_valid,
    output logic [15:0] snk_data,
    input  logic        snk_ready,
    output logic        rqst,
    output logic        rd_wr,
    output logic [16:0] start_addr,
    output logic [15:0] num_words,
    output logic        dev_ack,
    output logic [15:0] dev_data,
    input  logic        dma_ack,
    input  logic        end_flag,
    input  logic        error_flag,
    input  logic [15:0] dma_data,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        timeout
);
    typedef enum logic [2:0] {IDLE, REQ, XFER, DONE, ERR} state_t;

    localparam logic [FIFO_AW:0] DEPTH = (FIFO_AW+1)'(1) << FIFO_AW;
    localparam logic [FIFO_AW:0] TWO   = (FIFO_AW+1)'(2);
    localparam logic [FIFO_AW:0] ONE   = (FIFO_AW+1)'(1);

    state_t        state_q;
    logic          rd_wr_q, rqst_q, done_q, err_q, to_q;
    logic [16:0]   addr_q;
    logic [15:0]   words_q, rem_q;

    logic          accept, xfer_ack, fifo_clr, to_hit;
    logic          wf_push, wf_pop, rf_push, rf_pop;
    logic [15:0]   wf_head, rf_head;
    logic [FIFO_AW:0] wf_count, rf_count;
    logic          wr_go, rd_go;

    assign accept   = (state_q == IDLE) && cmd_valid;
    // Strobes after the last word are ignored so the FIFOs never over-run.
    assign xfer_ack = (state_q == XFER) && dma_ack && (rem_q != 16'd0);
    assign fifo_clr = accept || (state_q == ERR);

    assign src_ready = !rd_wr_q && (wf_count != DEPTH) &&
                       ((state_q == REQ) || (state_q == XFER));
    assign wf_push   = src_valid && src_ready;
    assign wf_pop    = xfer_ack && !rd_wr_q;
    assign rf_push   = xfer_ack && rd_wr_q;
    assign snk_valid = (rf_count != '0);
    assign rf_pop    = snk_valid && snk_ready;

    dma_dev_fifo #(.AW(FIFO_AW), .W(16)) u_wr_fifo (
        .clk(clk), .reset(reset), .clr_i(fifo_clr),
        .push_i(wf_push), .push_dat_i(src_data), .pop_i(wf_pop),
        .head_o(wf_head), .count_o(wf_count)
    );

    dma_dev_fifo #(.AW(FIFO_AW), .W(16)) u_rd_fifo (
        .clk(clk), .reset(reset), .clr_i(fifo_clr),
        .push_i(rf_push), .push_dat_i(dma_data), .pop_i(rf_pop),
        .head_o(rf_head), .count_o(rf_count)
    );

    // Write side keeps a spare word queued because the controller consumes one cycle late.
    assign wr_go   = (wf_count >= TWO) || ((wf_count >= ONE) && (rem_q <= 16'd1));
    assign rd_go   = (rf_count <= (DEPTH - TWO));
    assign dev_ack = (state_q == XFER) && (rem_q != 16'd0) && (rd_wr_q ? rd_go : wr_go);

`ifdef DMA_DEV_TIMEOUT_EN
    logic [15:0] wd_cnt_q;

    assign to_hit = (state_q == XFER) && !dma_ack && (wd_cnt_q == 16'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            wd_cnt_q <= '0;
        else if ((state_q != XFER) || dma_ack || to_hit)
            wd_cnt_q <= '0;
        else
            wd_cnt_q <= wd_cnt_q + 16'd1;
    end
`else
    assign to_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            rd_wr_q <= 1'b0;
            addr_q  <= '0;
            words_q <= '0;
            rem_q   <= '0;
            rqst_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            rqst_q <= 1'b0;
            done_q <= 1'b0;
            if (xfer_ack) rem_q <= rem_q - 16'd1;
            unique case (state_q)
                IDLE: if (accept) begin
                    rd_wr_q <= cmd_rd_wr;
                    addr_q  <= cmd_addr;
                    words_q <= cmd_words;
                    rem_q   <= cmd_words;
                    err_q   <= 1'b0;
                    to_q    <= 1'b0;
                    rqst_q  <= 1'b1;
                    state_q <= REQ;
                end
                REQ: state_q <= XFER;
                XFER: begin
                    if (error_flag) begin
                        err_q   <= 1'b1;
                        state_q <= ERR;
                    end else if (end_flag) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else if (to_hit) begin
                        err_q   <= 1'b1;
                        to_q    <= 1'b1;
                        state_q <= ERR;
                    end
                end
                DONE:    state_q <= IDLE;
                ERR:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready  = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign rqst       = rqst_q;
    assign done       = done_q;
    assign err        = err_q;
    assign timeout    = to_q;
    assign rd_wr      = rd_wr_q;
    assign start_addr = addr_q;
    assign num_words  = words_q;
    assign dev_data   = wf_head;
    assign snk_data   = rf_head;
endmodule

// File: tb/tb_dma_dev_if.sv
// Scoreboard bench for dma_dev_if: write, read with backpressure, overrun, error, reset, zero-length.
module tb_dma_dev_if;
`ifdef DMA_DEV_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 1024;
`endif

    logic        clk, reset;
    logic        cmd_valid, cmd_ready, cmd_rd_wr;
    logic [16:0] cmd_addr;
    logic [15:0] cmd_words;
    logic        src_valid, src_ready;
    logic [15:0] src_data;
    logic        snk_valid, snk_ready;
    logic [15:0] snk_data;
    logic        rqst, rd_wr, dev_ack;
    logic [16:0] start_addr;
    logic [15:0] num_words, dev_data, dma_data;
    logic        dma_ack, end_flag, error_flag;
    logic        busy, done, err, timeout;

    dma_dev_if #(.FIFO_AW(2), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rd_wr(cmd_rd_wr),
        .cmd_addr(cmd_addr), .cmd_words(cmd_words),
        .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
        .snk_valid(snk_valid), .snk_data(snk_data), .snk_ready(snk_ready),
        .rqst(rqst), .rd_wr(rd_wr), .start_addr(start_addr), .num_words(num_words),
        .dev_ack(dev_ack), .dev_data(dev_data),
        .dma_ack(dma_ack), .end_flag(end_flag), .error_flag(error_flag), .dma_data(dma_data),
        .busy(busy), .done(done), .err(err), .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] exp_q [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, " cmd_ready"}, cmd_ready, 1);
        check_eq({tag, " status"}, {busy, done, err, timeout, rqst, rd_wr}, 0);
        check_eq({tag, " handshakes"}, {dev_ack, src_ready, snk_valid}, 0);
        check_eq({tag, " start_addr"}, start_addr, 0);
        check_eq({tag, " num_words"}, num_words, 0);
        check_eq({tag, " data"}, {dev_data, snk_data}, 0);
    endtask

    task automatic send_cmd(input logic rw, input logic [16:0] a, input logic [15:0] w);
        cmd_valid = 1'b1; cmd_rd_wr = rw; cmd_addr = a; cmd_words = w;
        check_eq("cmd_ready idle", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        check_eq("rqst in REQ", rqst, 1);
        check_eq("busy in REQ", busy, 1);
    endtask

    task automatic end_xfer();
        end_flag = 1'b1;
        tick();
        end_flag = 1'b0;
        check_eq("done pulse", done, 1);
        tick();
        check_eq("done cleared", done, 0);
        check_eq("busy after done", busy, 0);
    endtask

    // Drain the read FIFO against the scoreboard; returns how many words came out.
    task automatic drain(input string tag, output int recv);
        recv = 0;
        snk_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (snk_valid) begin
                if (exp_q.size() == 0) check_eq({tag, " unexpected word"}, snk_data, 32'hFFFF_FFFF);
                else check_eq({tag, " snk_data"}, snk_data, exp_q.pop_front());
                recv++;
            end
            tick();
        end
        snk_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent, recv;
        cmd_valid = 0; cmd_rd_wr = 0; cmd_addr = 0; cmd_words = 0;
        src_valid = 0; src_data = 0; snk_ready = 0;
        dma_ack = 0; dma_data = 0; end_flag = 0; error_flag = 0;
        reset = 1'b0;
        #3 reset = 1'b1;
        tick(); tick();
        check_reset_outputs("reset");
        reset = 1'b0;
        tick();

        // Write of three words
        send_cmd(1'b0, 17'h0200, 16'd3);
        check_eq("wr start_addr", start_addr, 17'h0200);
        check_eq("wr num_words", num_words, 3);
        check_eq("wr rd_wr", rd_wr, 0);
        for (int k = 0; k < 3; k++) begin
            src_valid = 1'b1;
            src_data  = 16'h00A1 + 16'(k);
            check_eq("wr src_ready", src_ready, 1);
            if (src_ready) exp_q.push_back(src_data);
            tick();
        end
        src_valid = 1'b0;
        check_eq("rqst single cycle", rqst, 0);
        for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
            if (dev_ack) begin
                check_eq("wr dev_data", dev_data, exp_q.pop_front());
                dma_ack = 1'b1;
            end else dma_ack = 1'b0;
            tick();
        end
        dma_ack = 1'b0;
        check_eq("wr all words taken", exp_q.size(), 0);
        check_eq("wr dev_ack after last", dev_ack, 0);
        end_xfer();

        // Read of six words with the sink stalled
        send_cmd(1'b1, 17'h1000, 16'd6);
        tick();
        check_eq("rd rd_wr", rd_wr, 1);
        check_eq("rd src_ready", src_ready, 0);
        sent = 0;
        for (int c = 0; c < 6; c++) begin
            if (dev_ack && sent < 6) begin
                dma_ack = 1'b1; dma_data = 16'h00B0 + 16'(sent);
                exp_q.push_back(dma_data); sent++;
            end else dma_ack = 1'b0;
            tick();
        end
        dma_ack = 1'b0;
        check_eq("rd words before stall", sent, 3);
        check_eq("rd dev_ack stalled", dev_ack, 0);
        check_eq("rd snk_valid stalled", snk_valid, 1);
        snk_ready = 1'b1;
        recv = 0;
        for (int c = 0; c < 40 && recv < 6; c++) begin
            if (snk_valid) begin
                if (exp_q.size() == 0) check_eq("rd unexpected word", snk_data, 32'hFFFF_FFFF);
                else check_eq("rd snk_data", snk_data, exp_q.pop_front());
                recv++;
            end
            if (dev_ack && sent < 6) begin
                dma_ack = 1'b1; dma_data = 16'h00B0 + 16'(sent);
                exp_q.push_back(dma_data); sent++;
            end else dma_ack = 1'b0;
            tick();
        end
        dma_ack = 1'b0; snk_ready = 1'b0;
        check_eq("rd words delivered", recv, 6);
        check_eq("rd snk_valid empty", snk_valid, 0);
        end_xfer();

        // Extra strobe after the last word
        send_cmd(1'b1, 17'h0040, 16'd2);
        tick();
        dma_ack = 1'b1;
        dma_data = 16'h00C1; exp_q.push_back(dma_data); tick();
        dma_data = 16'h00C2; exp_q.push_back(dma_data); tick();
        check_eq("ovr dev_ack at zero", dev_ack, 0);
        dma_data = 16'hDEAD; tick();
        dma_ack = 1'b0;
        check_eq("ovr dev_ack stays 0", dev_ack, 0);
        drain("ovr", recv);
        check_eq("ovr word count", recv, 2);
        end_xfer();

        // Error and end in the same cycle
        send_cmd(1'b1, 17'h0080, 16'd4);
        tick();
        dma_ack = 1'b1;
        dma_data = 16'h00D1; tick();
        dma_data = 16'h00D2; tick();
        dma_ack = 1'b0;
        check_eq("err fifo loaded", snk_valid, 1);
        error_flag = 1'b1; end_flag = 1'b1;
        tick();
        error_flag = 1'b0; end_flag = 1'b0;
        check_eq("err in ERR", {err, done, busy}, 3'b101);
        tick();
        check_eq("err sticky idle", {err, done, busy}, 3'b100);
        check_eq("err fifo flushed", snk_valid, 0);
        check_eq("err cmd_ready", cmd_ready, 1);

        // Reset in the middle of a read
        send_cmd(1'b1, 17'h0123, 16'd5);
        check_eq("err cleared by cmd", err, 0);
        tick();
        dma_ack = 1'b1; dma_data = 16'h00E1; tick();
        dma_ack = 1'b0;
        check_eq("mid snk_valid", snk_valid, 1);
        reset = 1'b1;
        #1;
        check_reset_outputs("midreset");
        reset = 1'b0;
        tick();

        // Zero-length command still requests and completes
        send_cmd(1'b0, 17'h0000, 16'd0);
        tick();
        check_eq("zero dev_ack", dev_ack, 0);
        check_eq("zero busy", busy, 1);
        end_xfer();

`ifdef DMA_DEV_TIMEOUT_EN
        send_cmd(1'b1, 17'h0010, 16'd2);
        tick();
        repeat (15) tick();
        check_eq("to not yet", err, 0);
        tick();
        check_eq("to err", err, 1);
        check_eq("to timeout", timeout, 1);
        tick();
        check_eq("to idle sticky", {busy, timeout}, 2'b01);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/dma_dev_if.md
DMA_DEV_IF -- requirements
Module: dma_dev_if

Interface
REQ-001 The block SHALL have parameter FIFO_AW, default 2, meaning log2 of the depth of each internal word FIFO (4 entries).
REQ-002 The block SHALL have parameter TIMEOUT, default 1024, meaning the idle-cycle limit of the watchdog.
REQ-003 clk  in  1  clock; all state updates on the rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 cmd_valid / cmd_ready  in / out  1 / 1  command handshake; a command is accepted on a cycle where both are high.
REQ-006 cmd_rd_wr  in  1  transfer direction: 1 = memory-to-stream (read), 0 = stream-to-memory (write).
REQ-007 cmd_addr / cmd_words  in  17 / 16  byte start address / word count.
REQ-008 src_valid, src_data[15:0]  in; src_ready  out  write-direction stream input.
REQ-009 snk_valid, snk_data[15:0]  out; snk_ready  in  read-direction stream output.
REQ-010 rqst, rd_wr  out  1  request and direction to the DMA controller.
REQ-011 start_addr / num_words  out  17 / 16  transfer parameters to the DMA controller.
REQ-012 dev_ack  out  1  device-ready indication to the DMA controller.
REQ-013 dev_data  out  16  write data to the DMA controller.
REQ-014 dma_ack, end_flag, error_flag  in  1  controller word strobe, completion and error.
REQ-015 dma_data  in  16  read data from the DMA controller.
REQ-016 busy, done, err, timeout  out  1  status.

Function
REQ-017 The block SHALL implement an FSM with states IDLE, REQ, XFER, DONE and ERR.
REQ-018 IDLE: cmd_ready=1; on an accepted command, latch direction, address and word count, clear both FIFOs, clear err/timeout, and go to REQ.
REQ-019 REQ: rqst=1 for exactly one cycle, then go to XFER.
REQ-020 start_addr, num_words and rd_wr SHALL be driven from the latched registers and held stable from REQ until the FSM returns to IDLE.
REQ-021 XFER: on end_flag go to DONE; on error_flag go to ERR; error_flag wins if both assert in the same cycle.
REQ-022 DONE: done=1 for one cycle, then go to IDLE.
REQ-023 ERR: err=1, both FIFOs flushed, then go to IDLE; err SHALL stay high until the next command is accepted.
REQ-024 busy SHALL be 1 in every state except IDLE.
REQ-025 Write direction: src words are pushed into the write FIFO while it is not full; src_ready = !full and state is REQ or XFER; dev_data = write FIFO head.
REQ-026 Write direction: dev_ack = (fifo_count >= 2) or (fifo_count >= 1 and remaining words <= 1); this gives one word of headroom for the controller's registered consumption.
REQ-027 Write direction: each cycle in XFER with dma_ack=1 SHALL pop one word and decrement the 16-bit remaining counter.
REQ-028 Read direction: each cycle in XFER with dma_ack=1 SHALL push dma_data into the read FIFO and decrement remaining.
REQ-029 Read direction: dev_ack = (free entries >= 2); snk_valid = !empty; snk_data = read FIFO head; a pop occurs when snk_valid and snk_ready are both high.
REQ-030 Once remaining reaches 0, further dma_ack pulses SHALL be ignored (no push, no pop, no decrement), and dev_ack SHALL be 0.
REQ-031 A push and a pop in the same cycle SHALL leave the FIFO count unchanged; a push when full or a pop when empty SHALL have no effect.
REQ-032 FIFO pointers SHALL wrap modulo 2^FIFO_AW.
REQ-033 If cmd_words=0, the block SHALL still issue rqst and SHALL complete on the controller's end_flag.

Reset
REQ-034 While reset is high, the block SHALL asynchronously set state=IDLE, empty both FIFOs, and zero the latched registers and remaining counter.
REQ-035 Reset output values: all outputs 0, except cmd_ready=1.
REQ-036 Reset asserted mid-transfer SHALL abort the transfer with no done pulse.

Configuration
REQ-037 With DMA_DEV_TIMEOUT_EN defined, a 16-bit counter SHALL clear on every dma_ack or on leaving XFER, and increment on every other XFER cycle.
REQ-038 With DMA_DEV_TIMEOUT_EN defined, when the counter reaches TIMEOUT the FSM SHALL go to ERR with timeout=1 (sticky, like err).
REQ-039 Without DMA_DEV_TIMEOUT_EN, the counter SHALL not exist, timeout SHALL be tied to 0, and XFER SHALL wait indefinitely.

Verification
REQ-040 Write of 3 words: cmd (wr, 0x0200, 3); src 0xA1, 0xA2, 0xA3; dma_ack on 3 cycles -> dev_data sequence A1, A2, A3; end_flag -> done pulse, busy=0.
REQ-041 Read of 6 words with snk_ready=0: dev_ack drops once 3 words are held; then snk_ready=1 -> all 6 words delivered in order, no loss.
REQ-042 error_flag and end_flag asserted in the same XFER cycle -> ERR, err=1, done=0, FIFOs empty.
REQ-043 Extra dma_ack after 2 of 2 words -> no push, remaining stays 0.
REQ-044 reset asserted mid-read -> all outputs return to their reset values immediately; a new command is then accepted.
REQ-045 With DMA_DEV_TIMEOUT_EN and TIMEOUT=16, no dma_ack in XFER -> timeout=1, err=1 on the 16th cycle.
